// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter fetch stage.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_t;

  localparam int unsigned INST_BYTES = 4;

  // Word offset from the instruction, sign-extended and scaled to bytes.
  function automatic logic [31:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection (jr > jump > branch > sequential) and
// illegal-target detection against the instruction memory bounds.
module pc_next_calc
  import pc_fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 100
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output sel_t        sel,
  output logic        illegal
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - INST_BYTES);

  logic [31:0] seq_pc_s;

  assign seq_pc_s = pc + 32'd4;

  // Priority select of the redirect source.
  always_comb begin
    next_pc = seq_pc_s;
    sel     = SEL_SEQ;
    if (jr) begin
      next_pc = jr_target;
      sel     = SEL_JR;
    end else if (jump) begin
      next_pc = {seq_pc_s[31:28], jump_index, 2'b00};
      sel     = SEL_J;
    end else if (branch_taken) begin
      next_pc = seq_pc_s + branch_disp(branch_offset);
      sel     = SEL_BR;
    end else begin
      next_pc = seq_pc_s;
      sel     = SEL_SEQ;
    end
  end

  assign illegal = (next_pc[1:0] != 2'b00) || (next_pc > LAST_PC);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage feeding the instruction memory, with sticky fault on
// illegal targets. Optional performance counters under PC_PERF_CNT_EN.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
`ifdef PC_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count,
`endif
  output logic [1:0]  state
);

  state_t      state_r, state_next_s;
  logic [31:0] pc_r;
  logic        pc_valid_r;
  logic        fault_r;
  logic [31:0] fault_pc_r;
  logic [31:0] next_pc_s;
  sel_t        sel_s;
  logic        illegal_s;
  logic        pc_load_s;
  logic        fault_set_s;

  pc_next_calc #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_next (
    .pc            (pc_r),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_pc       (next_pc_s),
    .sel           (sel_s),
    .illegal       (illegal_s)
  );

  // Next-state and update-enable decode.
  always_comb begin
    state_next_s = state_r;
    pc_load_s    = 1'b0;
    fault_set_s  = 1'b0;
    case (state_r)
      BOOT: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (illegal_s) begin
            state_next_s = FAULT;
            fault_set_s  = 1'b1;
          end else begin
            pc_load_s = 1'b1;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      FAULT: begin
        state_next_s = FAULT;
      end
      default: begin
        state_next_s = BOOT;
      end
    endcase
  end

  // Architectural PC, FSM and fault capture; pc_valid is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      pc_valid_r <= 1'b0;
      fault_r    <= 1'b0;
      fault_pc_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_next_s;
      pc_valid_r <= (state_next_s == RUN);
      if (pc_load_s) begin
        pc_r <= next_pc_s;
      end
      if (fault_set_s) begin
        fault_r    <= 1'b1;
        fault_pc_r <= next_pc_s;
      end
    end
  end

`ifdef PC_PERF_CNT_EN
  logic [31:0] fetch_count_r;
  logic [31:0] redirect_count_r;

  // Counters advance only on legal updates, so they freeze naturally in FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_r    <= 32'd0;
      redirect_count_r <= 32'd0;
    end else if (pc_load_s) begin
      fetch_count_r <= fetch_count_r + 32'd1;
      if (sel_s != SEL_SEQ) begin
        redirect_count_r <= redirect_count_r + 32'd1;
      end
    end
  end

  assign fetch_count    = fetch_count_r;
  assign redirect_count = redirect_count_r;
`else
  logic unused_sel_s;
  assign unused_sel_s = ^sel_s;
`endif

  assign pc       = pc_r;
  assign pc_plus4 = pc_r + 32'd4;
  assign pc_valid = pc_valid_r;
  assign fault    = fault_r;
  assign fault_pc = fault_pc_r;
  assign state    = state_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (default IMEM_BYTES=100).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  state;
`ifdef PC_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_index     (jump_index),
    .jr             (jr),
    .jr_target      (jr_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .pc_valid       (pc_valid),
    .fault          (fault),
    .fault_pc       (fault_pc),
`ifdef PC_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count),
`endif
    .state          (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0000;
    jump          = 1'b0;
    jump_index    = 26'h0;
    jr            = 1'b0;
    jr_target     = 32'h0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check_eq("reset_pc", pc, 32'd0);
    check_eq("reset_state", {30'd0, state}, 32'd0);
    check_eq("reset_valid", {31'd0, pc_valid}, 32'd0);
    check_eq("reset_fault", {31'd0, fault}, 32'd0);
    check_eq("reset_fault_pc", fault_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("boot_state", {30'd0, state}, 32'd0);
    check_eq("boot_valid", {31'd0, pc_valid}, 32'd0);
    tick();
    check_eq("run_state", {30'd0, state}, 32'd1);
    check_eq("run_pc0", pc, 32'd0);
    check_eq("run_valid", {31'd0, pc_valid}, 32'd1);
    check_eq("pc_plus4_0", pc_plus4, 32'd4);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("seq_a", pc, 32'(4 * i));
    end

    // Stall at 12 with a branch pending, then release it.
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_hold", pc, 32'd12);
    end
    stall = 1'b0;
    tick();
    check_eq("stall_release_br", pc, 32'd16);

    // 20 + (-5*4) = 0
    branch_offset = 16'hFFFB;
    tick();
    check_eq("branch_back", pc, 32'd0);
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("seq_b", pc, 32'(4 * i));
    end

    // 24 + 3*4 = 36
    branch_taken = 1'b1; branch_offset = 16'h0003;
    tick();
    check_eq("branch_fwd", pc, 32'd36);

    jump = 1'b1; jump_index = 26'h10;
    tick();
    check_eq("jump_over_branch", pc, 32'd64);

    jr = 1'b1; jr_target = 32'd8;
    tick();
    check_eq("jr_over_jump_a", pc, 32'd8);
    jr_target = 32'd24;
    tick();
    check_eq("jr_over_jump_b", pc, 32'd24);
`ifdef PC_PERF_CNT_EN
    check_eq("fetch_count", fetch_count, 32'd14);
    check_eq("redirect_count", redirect_count, 32'd6);
`endif

    // Misaligned register target faults.
    clear_inputs();
    jr = 1'b1; jr_target = 32'h0000_0022;
    tick();
    check_eq("fault_flag", {31'd0, fault}, 32'd1);
    check_eq("fault_pc_mis", fault_pc, 32'd34);
    check_eq("fault_pc_hold", pc, 32'd24);
    check_eq("fault_valid", {31'd0, pc_valid}, 32'd0);
    check_eq("fault_state", {30'd0, state}, 32'd2);
    clear_inputs();
    jump = 1'b1; jump_index = 26'h4;
    tick();
    tick();
    check_eq("fault_sticky_pc", pc, 32'd24);
    check_eq("fault_sticky_fpc", fault_pc, 32'd34);
    check_eq("fault_sticky_st", {30'd0, state}, 32'd2);
`ifdef PC_PERF_CNT_EN
    check_eq("fetch_frozen", fetch_count, 32'd14);
    check_eq("redirect_frozen", redirect_count, 32'd6);
`endif

    // Asynchronous reset out of FAULT.
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("areset_pc", pc, 32'd0);
    check_eq("areset_fault", {31'd0, fault}, 32'd0);
    check_eq("areset_fpc", fault_pc, 32'd0);
    check_eq("areset_state", {30'd0, state}, 32'd0);
    #2;
    clear_inputs();
    stall = 1'b1;
    rst_n = 1'b1;
    tick();
    check_eq("boot_ignores_stall", {30'd0, state}, 32'd1);
    check_eq("boot_pc", pc, 32'd0);

    // Sequential run off the end of memory.
    stall = 1'b0; jr = 1'b1; jr_target = 32'd92;
    tick();
    check_eq("jr_92", pc, 32'd92);
    check_eq("pc_plus4_92", pc_plus4, 32'd96);
    clear_inputs();
    tick();
    check_eq("seq_96_legal", pc, 32'd96);
    check_eq("valid_96", {31'd0, pc_valid}, 32'd1);
    tick();
    check_eq("end_fault", {31'd0, fault}, 32'd1);
    check_eq("end_fault_pc", fault_pc, 32'd100);
    check_eq("end_pc_hold", pc, 32'd96);
    check_eq("end_valid", {31'd0, pc_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
